// File: rtl/timing_bank_pkg.sv
// rtl/timing_bank_pkg.sv - shared state encodings and mode constants for the timer bank
package timing_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } chan_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timing_bank_chan.sv
// rtl/timing_bank_chan.sv - one timer channel: state machine, counter and sticky expiry flag
module timing_bank_chan
    import timing_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic             mode_i,
    input  logic             int_clr_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             status_o,
    output logic [WIDTH-1:0] count_o,
    output logic             int_o
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             int_q, int_d;
    logic             expire;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expire  = 1'b0;
        if (halt_i) begin
            state_d = ST_IDLE;
        end else if (start_i) begin
            state_d = ST_RUN;
            count_d = '0;
        end else if (state_q == ST_RUN && tick_i) begin
            if (count_q == term_i) begin
                expire = 1'b1;
                if (mode_i == MODE_PERIODIC) begin
                    count_d = '0;
                end else begin
                    state_d = ST_EXPIRED;
                end
            end else begin
                // Equality-only compare: a terminal count lowered below the
                // current count is reached again after the natural wrap.
                count_d = count_q + WIDTH'(1);
            end
        end
        int_d = expire | (int_q & ~int_clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            int_q   <= int_d;
        end
    end

    assign status_o = (state_q == ST_RUN);
    assign count_o  = count_q;
    assign int_o    = int_q;

endmodule

// File: rtl/timing_bank.sv
// rtl/timing_bank.sv - NCH programmable interval timers sharing one clock prescaler
module timing_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int PSC_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PSC_W-1:0]     ro_prescale,
    input  logic [NCH-1:0]       ro_trig_start,
    input  logic [NCH-1:0]       ro_trig_halt,
    input  logic [NCH-1:0]       ro_mode,
    input  logic [NCH-1:0]       ro_int_clr,
    input  logic [NCH-1:0]       ro_int_en,
    input  logic [NCH*WIDTH-1:0] ro_termcount,
    output logic [NCH-1:0]       rf_status,
    output logic [NCH*WIDTH-1:0] rf_currcount,
    output logic [NCH-1:0]       rf_int,
    output logic                 rf_irq
);

    logic [PSC_W-1:0] psc_q, psc_d;
    logic             irq_q, irq_d;
    logic             tick;

    // >= rather than == so that lowering the prescale below the running
    // count recovers on the next cycle instead of after a full wrap.
    assign tick  = (psc_q >= ro_prescale);
    assign psc_d = tick ? '0 : psc_q + PSC_W'(1);
    assign irq_d = |(rf_int & ro_int_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= '0;
            irq_q <= 1'b0;
        end else begin
            psc_q <= psc_d;
            irq_q <= irq_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        timing_bank_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (reset),
            .tick_i    (tick),
            .start_i   (ro_trig_start[i]),
            .halt_i    (ro_trig_halt[i]),
            .mode_i    (ro_mode[i]),
            .int_clr_i (ro_int_clr[i]),
            .term_i    (ro_termcount[i*WIDTH +: WIDTH]),
            .status_o  (rf_status[i]),
            .count_o   (rf_currcount[i*WIDTH +: WIDTH]),
            .int_o     (rf_int[i])
        );
    end

    assign rf_irq = irq_q;

endmodule

// File: tb/tb_timing_bank.sv
// tb/tb_timing_bank.sv - directed table and sequence checks for timing_bank
module tb_timing_bank;

    localparam int NCH   = 4;
    localparam int W     = 8;
    localparam int PSC_W = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [PSC_W-1:0]     ro_prescale = '0;
    logic [NCH-1:0]       ro_trig_start = '0;
    logic [NCH-1:0]       ro_trig_halt = '0;
    logic [NCH-1:0]       ro_mode = '0;
    logic [NCH-1:0]       ro_int_clr = '0;
    logic [NCH-1:0]       ro_int_en = '1;
    logic [NCH*W-1:0]     ro_termcount = '0;
    logic [NCH-1:0]       rf_status;
    logic [NCH*W-1:0]     rf_currcount;
    logic [NCH-1:0]       rf_int;
    logic                 rf_irq;

    timing_bank #(.NCH(NCH), .WIDTH(W), .PSC_W(PSC_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ro_prescale  (ro_prescale),
        .ro_trig_start(ro_trig_start),
        .ro_trig_halt (ro_trig_halt),
        .ro_mode      (ro_mode),
        .ro_int_clr   (ro_int_clr),
        .ro_int_en    (ro_int_en),
        .ro_termcount (ro_termcount),
        .rf_status    (rf_status),
        .rf_currcount (rf_currcount),
        .rf_int       (rf_int),
        .rf_irq       (rf_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    typedef struct {
        logic       start;
        logic       clr;
        logic       exp_status;
        logic [7:0] exp_cnt;
        logic       exp_int;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic logic [W-1:0] cnt(input int i);
        return rf_currcount[i*W +: W];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, n, mx;
        logic seen;
        logic [3:0] exp_st[6];
        logic [3:0] exp_in[6];
        logic       exp_iq[6];

        // Test 1 table: ch0 one-shot term 10, prescale 0
        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
        for (int k = 1; k <= 10; k++) vecs[k] = '{1'b0, 1'b0, 1'b1, 8'(k), 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd10, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd10, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd10, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'd10, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0};

        repeat (3) step();
        chk("reset_status", 32'(rf_status), 0);
        chk("reset_count", 32'(rf_currcount), 0);
        chk("reset_int", 32'(rf_int), 0);
        chk("reset_irq", 32'(rf_irq), 0);
        reset = 1'b1;
        step();

        ro_termcount[0*W +: W] = 8'd10;
        for (int k = 0; k < 16; k++) begin
            ro_trig_start[0] = vecs[k].start;
            ro_int_clr[0]    = vecs[k].clr;
            step();
            chk($sformatf("t1_status[%0d]", k), 32'(rf_status[0]), 32'(vecs[k].exp_status));
            chk($sformatf("t1_count[%0d]", k), 32'(cnt(0)), 32'(vecs[k].exp_cnt));
            chk($sformatf("t1_int[%0d]", k), 32'(rf_int[0]), 32'(vecs[k].exp_int));
            chk($sformatf("t1_irq[%0d]", k), 32'(rf_irq), 32'(vecs[k].exp_irq));
        end
        ro_trig_start = '0;
        ro_int_clr = '0;

        // Test 2: ch1 periodic term 4, prescale 3 -> 20 clk period
        ro_prescale = 16'd3;
        ro_mode[1] = 1'b1;
        ro_termcount[1*W +: W] = 8'd4;
        ro_trig_start[1] = 1'b1;
        step();
        ro_trig_start[1] = 1'b0;
        mx = 0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (int'(cnt(1)) > mx) mx = int'(cnt(1));
            if (rf_int[1]) seen = 1'b1;
        end
        chk("t2_first_expiry", 32'(seen), 1);
        t1 = cycle;
        ro_int_clr[1] = 1'b1;
        step();
        ro_int_clr[1] = 1'b0;
        chk("t2_int_cleared", 32'(rf_int[1]), 0);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (int'(cnt(1)) > mx) mx = int'(cnt(1));
            if (rf_int[1]) seen = 1'b1;
        end
        chk("t2_second_expiry", 32'(seen), 1);
        t2 = cycle;
        chk("t2_period", 32'(t2 - t1), 20);
        chk("t2_max_count", 32'(mx), 4);
        ro_int_clr[1] = 1'b1;
        step();
        ro_int_clr[1] = 1'b0;
        for (int k = 0; k < 40 && cycle < t2 + 19; k++) step();
        ro_int_clr[1] = 1'b1;
        step();
        ro_int_clr[1] = 1'b0;
        chk("t2_set_beats_clr", 32'(rf_int[1]), 1);
        chk("t2_periodic_count", 32'(cnt(1)), 0);
        chk("t2_periodic_status", 32'(rf_status[1]), 1);
        step();
        chk("t2_int_sticky", 32'(rf_int[1]), 1);
        ro_trig_halt[1] = 1'b1;
        step();
        ro_trig_halt[1] = 1'b0;
        chk("t2_halt_status", 32'(rf_status[1]), 0);
        chk("t2_halt_keeps_int", 32'(rf_int[1]), 1);

        // Test 3: ch2 halt+start together at count 7
        ro_prescale = 16'd0;
        step();
        ro_termcount[2*W +: W] = 8'd50;
        ro_trig_start[2] = 1'b1;
        step();
        ro_trig_start[2] = 1'b0;
        repeat (7) step();
        chk("t3_count7", 32'(cnt(2)), 7);
        ro_trig_start[2] = 1'b1;
        ro_trig_halt[2] = 1'b1;
        step();
        ro_trig_start[2] = 1'b0;
        ro_trig_halt[2] = 1'b0;
        chk("t3_halt_wins_status", 32'(rf_status[2]), 0);
        chk("t3_halt_wins_count", 32'(cnt(2)), 7);
        repeat (3) step();
        chk("t3_idle_holds", 32'(cnt(2)), 7);
        ro_trig_start[2] = 1'b1;
        step();
        ro_trig_start[2] = 1'b0;
        chk("t3_restart_status", 32'(rf_status[2]), 1);
        chk("t3_restart_count", 32'(cnt(2)), 0);
        step();
        chk("t3_restart_inc", 32'(cnt(2)), 1);
        ro_trig_halt[2] = 1'b1;
        step();
        ro_trig_halt[2] = 1'b0;

        // Test 4: ch3 term lowered below count -> expires after wrap
        ro_int_clr = '1;
        step();
        ro_int_clr = '0;
        ro_termcount[3*W +: W] = 8'd20;
        ro_trig_start[3] = 1'b1;
        step();
        ro_trig_start[3] = 1'b0;
        repeat (9) step();
        chk("t4_count9", 32'(cnt(3)), 9);
        ro_termcount[3*W +: W] = 8'd5;
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            n++;
            if (rf_int[3]) seen = 1'b1;
        end
        chk("t4_expired", 32'(seen), 1);
        chk("t4_edges_to_expiry", 32'(n), 253);
        chk("t4_final_count", 32'(cnt(3)), 5);
        chk("t4_final_status", 32'(rf_status[3]), 0);

        // Test 5: all channels together, terms 1..4, ch0 masked
        exp_st = '{4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        exp_in = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        exp_iq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ro_int_en = 4'b1110;
        ro_mode = '0;
        for (int i = 0; i < NCH; i++) ro_termcount[i*W +: W] = 8'(i + 1);
        ro_int_clr = '1;
        step();
        ro_int_clr = '0;
        ro_trig_start = '1;
        for (int k = 0; k < 6; k++) begin
            step();
            ro_trig_start = '0;
            chk($sformatf("t5_status[%0d]", k), 32'(rf_status), 32'(exp_st[k]));
            chk($sformatf("t5_int[%0d]", k), 32'(rf_int), 32'(exp_in[k]));
            chk($sformatf("t5_irq[%0d]", k), 32'(rf_irq), 32'(exp_iq[k]));
        end
        ro_int_en = 4'b0001;
        step();
        step();
        chk("t5_ch0_only_irq", 32'(rf_irq), 1);

        // Test 6: asynchronous reset mid-count
        ro_int_en = '1;
        ro_mode = '1;
        for (int i = 0; i < NCH; i++) ro_termcount[i*W +: W] = 8'd100;
        ro_trig_start = '1;
        step();
        ro_trig_start = '0;
        repeat (10) step();
        chk("t6_pre_count", 32'(cnt(2)), 10);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_status", 32'(rf_status), 0);
        chk("t6_rst_count", 32'(rf_currcount), 0);
        chk("t6_rst_int", 32'(rf_int), 0);
        chk("t6_rst_irq", 32'(rf_irq), 0);
        step();
        reset = 1'b1;
        ro_mode = '0;
        ro_termcount[0*W +: W] = 8'd2;
        ro_trig_start[0] = 1'b1;
        step();
        ro_trig_start[0] = 1'b0;
        chk("t6_post_status", 32'(rf_status), 4'b0001);
        chk("t6_post_count", 32'(cnt(0)), 0);
        repeat (3) step();
        chk("t6_post_int", 32'(rf_int), 4'b0001);
        chk("t6_post_final", 32'(cnt(0)), 2);
        step();
        chk("t6_post_irq", 32'(rf_irq), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
